// File: rtl/approx_err_accum_if.sv
// Sample stream into the error accumulator: approximate/exact product pair with valid/ready.
// The master drives a sample and holds it until the cycle in_ready is seen high.
interface approx_err_accum_if #(
    parameter int PW = 17
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] prod_apx;
    logic [PW-1:0] prod_exact;

    modport master (
        output in_valid,
        output prod_apx,
        output prod_exact,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  prod_apx,
        input  prod_exact,
        output in_ready
    );
endinterface

// File: rtl/approx_err_accum.sv
// Error-distance statistics (sum/max/count of |apx-exact|) over an N-sample run; results lag a transfer by 2 edges.
// Backpressure: in_ready only in RUN while fewer than N samples accepted; no bubbles for back-to-back input.
module approx_err_accum #(
    parameter int PW    = 17,
    parameter int CNT_W = 16,
    parameter int ACC_W = 33
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_samples,
    approx_err_accum_if.slave  smp,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   sum_ed,
    output logic [PW-1:0]      max_ed,
    output logic [CNT_W-1:0]   err_count,
    output logic [CNT_W-1:0]   sample_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] n_lat;

    logic             ready;
    logic             start_ok;
    logic             xfer;
    logic             last_xfer;
    logic             drain_end;

    // Input capture stage, so the ED subtract sees registered operands
    logic             s0_vld;
    logic             s0_last;
    logic [PW-1:0]    s0_apx;
    logic [PW-1:0]    s0_exact;

    logic             s1_vld;
    logic             s1_last;
    logic             s1_err;
    logic [PW-1:0]    s1_ed;

    logic [PW-1:0]    ed_c;
    logic [ACC_W:0]   sum_wide;
    logic [ACC_W-1:0] sum_nxt;

    assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
    assign xfer      = smp.in_valid && ready;
    assign last_xfer = xfer && (sample_count == (n_lat - CNT_W'(1)));
    assign drain_end = s1_vld && s1_last;
    assign smp.in_ready = ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_nxt = (num_samples == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_xfer) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_end) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state and counter only, never from in_valid
    always_comb begin
        busy  = 1'b0;
        ready = 1'b0;
        case (state)
            S_RUN: begin
                busy  = 1'b1;
                ready = (sample_count < n_lat);
            end
            S_DRAIN: busy = 1'b1;
            default: begin
                busy  = 1'b0;
                ready = 1'b0;
            end
        endcase
    end

    always_comb begin
        ed_c     = (s0_apx >= s0_exact) ? (s0_apx - s0_exact) : (s0_exact - s0_apx);
        sum_wide = (ACC_W+1)'(sum_ed) + (ACC_W+1)'(s1_ed);
        sum_nxt  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld   <= 1'b0;
            s0_last  <= 1'b0;
            s0_apx   <= '0;
            s0_exact <= '0;
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_err   <= 1'b0;
            s1_ed    <= '0;
        end else begin
            s0_vld <= xfer;
            s1_vld <= s0_vld;
            if (xfer) begin
                s0_apx   <= smp.prod_apx;
                s0_exact <= smp.prod_exact;
                s0_last  <= last_xfer;
            end
            if (s0_vld) begin
                s1_ed   <= ed_c;
                s1_err  <= (ed_c != '0);
                s1_last <= s0_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat        <= '0;
            done         <= 1'b0;
            sum_ed       <= '0;
            max_ed       <= '0;
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            done <= (start_ok && (num_samples == '0)) || ((state == S_DRAIN) && drain_end);
            if (start_ok) begin
                n_lat        <= num_samples;
                sum_ed       <= '0;
                max_ed       <= '0;
                err_count    <= '0;
                sample_count <= '0;
            end else begin
                if (xfer) begin
                    sample_count <= sample_count + CNT_W'(1);
                end
                // Saturation is sticky: once all ones, adding any ED keeps all ones
                if (s1_vld) begin
                    sum_ed <= sum_nxt;
                    if (s1_ed > max_ed) begin
                        max_ed <= s1_ed;
                    end
                    if (s1_err && (err_count != {CNT_W{1'b1}})) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: doc/approx_err_accum.md
Name: approx_err_accum

Overview:
- Streaming error-statistics collector placed directly downstream of the 8-bit approximate multiplier tops (17-bit product).
- Each sample carries the approximate product and the exact reference product.
- The block computes the error distance ED = |apx - exact| through a 2-stage pipeline.
- Over a run of N samples it accumulates sum of ED, maximum ED and the count of erroneous results, for MED/ER/WCE reporting.

Parameters:
PW, 17, product width (8x8 multiplier output incl. carry-out bit)
CNT_W, 16, width of sample-count and error-count fields
ACC_W, 33, width of ED sum accumulator

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin run; honoured only in IDLE or DONE
num_samples  input  CNT_W  samples in run (N), latched on accepted start
in_valid  input  1  sample present
in_ready  output  1  block accepts sample this cycle
prod_apx  input  PW  approximate product
prod_exact  input  PW  exact product
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse, results final
sum_ed  output  ACC_W  sum of ED, saturating
max_ed  output  PW  largest ED seen
err_count  output  CNT_W  samples with ED != 0
sample_count  output  CNT_W  samples accepted in current or last run

Behaviour:
- Reset (async, rst_n low): state IDLE; in_ready=0, busy=0, done=0, sum_ed=0, max_ed=0, err_count=0, sample_count=0, pipeline valid bits=0. Takes effect immediately mid-run; partial results are discarded.
- States:
  - IDLE --start--> RUN (N>0) or DONE (N==0).
  - RUN --last sample accepted--> DRAIN.
  - DRAIN --pipeline empty--> DONE.
  - DONE --start--> RUN/DONE as from IDLE.
  - start in RUN/DRAIN is ignored; num_samples is not re-latched.
- Accepted start (edge E0): latch N; clear sum_ed, max_ed, err_count, sample_count. in_ready is high from the cycle after E0.
- N==0: done pulses in the cycle after E0; all results are 0.
- in_ready = (state==RUN) && (sample_count < N). It is combinational on state/counter only, never on in_valid.
- Transfer = in_valid && in_ready at rising edge. sample_count increments on each transfer. The transfer making sample_count==N moves the state to DRAIN. in_valid outside RUN is ignored.
- Pipeline:
  - stage 1: registers ED (unsigned, PW bits; computed as apx-exact if apx>=exact, else exact-apx) plus an error flag.
  - stage 2: sum_ed += ED, saturating at 2^ACC_W-1 and holding once saturated. max_ed = max(max_ed, ED). err_count += flag, saturating at 2^CNT_W-1.
- Latency: a sample transferred at edge E is reflected in the outputs after edge E+2. Back-to-back transfers every cycle are supported with no bubbles.
- done: registered, asserted in the same cycle the last sample's contribution first appears on the outputs, i.e. cycle after edge L+2 for last transfer at L. It is high for exactly one cycle.
- DONE state: busy=0, in_ready=0. All result outputs hold until the next accepted start or reset.
- Result outputs are directly registered (no combinational path from inputs).
- Outputs are intermediate and update live during RUN/DRAIN.

Test Plan:
- Reset mid-run: N=10, transfer 4 samples with ED=5, pull rst_n low asynchronously -> all outputs 0 immediately, state IDLE, in_ready=0; restart with N=1 works normally.
- Basic run, N=4, back-to-back pairs (apx,exact) = (100,100),(90,100),(130,100),(0,0) -> done pulses 2 cycles after 4th transfer (single cycle); sum_ed=40, max_ed=30, err_count=2, sample_count=4; in_ready drops the cycle after the 4th transfer.
- Gapped in_valid: N=3, in_valid toggling 1/0 with ED=1,2,3 -> sum_ed=6, max_ed=3; done timing tied to last transfer; extra in_valid after last transfer not counted.
- N=0 start -> done pulse cycle after start, busy never high, all results 0. Start asserted during RUN -> ignored, N unchanged.
- Extremes: apx=0x1FFFF, exact=0 -> ED=131071=max_ed. Preload sum_ed near 2^ACC_W-1 (or ACC_W=18 override) -> sum_ed saturates at all ones and stays there.
- Restart from DONE: results of previous run held until start; start clears all outputs next cycle and a new N=2 run reports only its own samples.
